// File: rtl/nr_iter_ctrl.sv
// Iteration sequencer: re-launches a single-step Newton/Broyden core until convergence, iteration limit, non-finite result or timeout.
// Latency: start -> core_start in 1 cycle; core_stb -> done or next core_start in 2 cycles.
// Backpressure: none; start is ignored while busy and core_stb is ignored outside WAIT.
module nr_iter_ctrl #(
    parameter int N_VARS   = 3,
    parameter int N_STATE  = 12,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5,
    parameter int TOL_LSB  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [32*N_VARS-1:0]    init_x,
    input  logic [32*N_STATE-1:0]   init_state,
    output logic                    busy,
    output logic                    core_start,
    output logic [32*N_VARS-1:0]    core_x,
    output logic [32*N_STATE-1:0]   core_state,
    input  logic                    core_stb,
    input  logic [32*N_VARS-1:0]    core_next_x,
    input  logic [32*N_STATE-1:0]   core_next_state,
    output logic                    done,
    output logic [1:0]              status,
    output logic [ITER_W-1:0]       iter_count,
    output logic [32*N_VARS-1:0]    x_out,
    output logic [32*N_STATE-1:0]   state_out
);

    localparam int          TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [23:0] TOL   = 24'(1) << TOL_LSB;

    localparam logic [1:0] ST_CONV    = 2'd0;
    localparam logic [1:0] ST_MAXITER = 2'd1;
    localparam logic [1:0] ST_NONFIN  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } fsm_t;

    fsm_t                   state_q, state_d;
    logic [32*N_VARS-1:0]   x_q, cand_x;
    logic [32*N_STATE-1:0]  st_q, cand_st;
    logic [ITER_W-1:0]      iter_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [1:0]             status_q, status_d;

    logic load_init, capture, commit, status_we, tmo_inc, tmo_clr;
    logic all_conv, non_finite;

    // Both-zero exponents count as converged regardless of mantissa; the
    // 24-bit absolute difference keeps the comparison wrap-free.
    function automatic logic var_conv(input logic [31:0] cand, input logic [31:0] cur);
        logic [23:0] ma, mb, diff;
        ma   = {1'b0, cand[22:0]};
        mb   = {1'b0, cur[22:0]};
        diff = (ma >= mb) ? (ma - mb) : (mb - ma);
        if (cand[30:23] == 8'd0 && cur[30:23] == 8'd0)
            return 1'b1;
        return (cand[31] == cur[31]) && (cand[30:23] == cur[30:23]) && (diff < TOL);
    endfunction

    always_comb begin
        all_conv   = 1'b1;
        non_finite = 1'b0;
        for (int i = 0; i < N_VARS; i++) begin
            if (cand_x[32*i+23 +: 8] == 8'hFF)
                non_finite = 1'b1;
            if (!var_conv(cand_x[32*i +: 32], x_q[32*i +: 32]))
                all_conv = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        load_init = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        status_we = 1'b0;
        tmo_inc   = 1'b0;
        tmo_clr   = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        load_init = 1'b1;
                        state_d   = S_LAUNCH;
                    end
                end
                S_LAUNCH: state_d = S_WAIT;
                S_WAIT: begin
                    tmo_inc = 1'b1;
                    if (core_stb) begin
                        capture = 1'b1;
                        state_d = S_CHECK;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        status_we = 1'b1;
                        status_d  = ST_TIMEOUT;
                        state_d   = S_DONE;
                    end
                end
                S_CHECK: begin
                    // A non-finite candidate is dropped so x_out keeps the last finite iterate.
                    if (non_finite) begin
                        status_we = 1'b1;
                        status_d  = ST_NONFIN;
                        state_d   = S_DONE;
                    end else begin
                        commit = 1'b1;
                        if (all_conv) begin
                            status_we = 1'b1;
                            status_d  = ST_CONV;
                            state_d   = S_DONE;
                        end else if (iter_q == ITER_W'(MAX_ITER)) begin
                            status_we = 1'b1;
                            status_d  = ST_MAXITER;
                            state_d   = S_DONE;
                        end else begin
                            tmo_clr = 1'b1;
                            state_d = S_LAUNCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        core_start = (state_q == S_LAUNCH);
        done       = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            st_q     <= '0;
            cand_x   <= '0;
            cand_st  <= '0;
            iter_q   <= '0;
            tmo_q    <= '0;
            status_q <= '0;
        end else begin
            if (load_init) begin
                x_q    <= init_x;
                st_q   <= init_state;
                iter_q <= '0;
                tmo_q  <= '0;
            end
            if (tmo_clr)
                tmo_q <= '0;
            else if (tmo_inc)
                tmo_q <= tmo_q + TMO_W'(1);
            if (capture) begin
                cand_x  <= core_next_x;
                cand_st <= core_next_state;
                iter_q  <= iter_q + ITER_W'(1);
            end
            if (commit) begin
                x_q  <= cand_x;
                st_q <= cand_st;
            end
            if (status_we)
                status_q <= status_d;
        end
    end

    assign core_x     = x_q;
    assign core_state = st_q;
    assign x_out      = x_q;
    assign state_out  = st_q;
    assign status     = status_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_nr_iter_ctrl.sv
// Directed bench for nr_iter_ctrl with a behavioural core that strobes three cycles after each launch.
module tb_nr_iter_ctrl;

    localparam int NV = 3;
    localparam int NS = 12;

    localparam int M_ECHO  = 0;
    localparam int M_FIRST = 1;
    localparam int M_ADD   = 2;
    localparam int M_NAN2  = 3;
    localparam int M_NEVER = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [32*NV-1:0] init_x = '0;
    logic [32*NS-1:0] init_state = '0;
    logic             busy, core_start, done;
    logic [32*NV-1:0] core_x, x_out;
    logic [32*NS-1:0] core_state, state_out;
    logic             core_stb = 1'b0;
    logic [32*NV-1:0] core_next_x = '0;
    logic [32*NS-1:0] core_next_state = '0;
    logic [1:0]       status;
    logic [4:0]       iter_count;

    int tests = 0;
    int fails = 0;
    int mode = M_ECHO;
    logic [31:0] alt_x0 = '0;

    int n_start, first_cs, done_cyc;
    int calls = 0;
    int cd = 0;
    logic [32*NV-1:0] rx;
    logic [32*NS-1:0] rs;
    logic [32*NV-1:0] exp_x;
    logic [32*NS-1:0] exp_s;
    int seen_done, seen_busy, seen_stb;

    nr_iter_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .init_x(init_x), .init_state(init_state),
        .busy(busy), .core_start(core_start), .core_x(core_x), .core_state(core_state),
        .core_stb(core_stb), .core_next_x(core_next_x), .core_next_state(core_next_state),
        .done(done), .status(status), .iter_count(iter_count),
        .x_out(x_out), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Core model: result appears three cycles after the launch pulse.
    always @(negedge clk) begin
        core_stb = 1'b0;
        if (!busy)
            calls = 0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                core_stb        = 1'b1;
                core_next_x     = rx;
                core_next_state = rs;
            end
        end
        if (core_start) begin
            calls = calls + 1;
            rx = core_x;
            rs = core_state;
            if (mode == M_ADD || mode == M_NAN2) begin
                for (int i = 0; i < NV; i++) rx[32*i +: 32] = rx[32*i +: 32] + 32'h10;
                for (int j = 0; j < NS; j++) rs[32*j +: 32] = rs[32*j +: 32] + 32'h1;
            end
            if (mode == M_FIRST && calls == 1) rx[31:0] = alt_x0;
            if (mode == M_NAN2 && calls == 2) rx[63:32] = 32'h7fc00000;
            cd = (mode == M_NEVER) ? 0 : 3;
        end
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One solve; cycle 1 is the cycle right after the edge that samples start.
    task automatic run(input int budget);
        int n;
        @(negedge clk);
        start = 1'b1;
        n = 0; n_start = 0; first_cs = 0; done_cyc = 0;
        while (n < budget && done_cyc == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (core_start) begin
                n_start++;
                if (first_cs == 0) first_cs = n;
            end
            if (done) done_cyc = n;
        end
        start = 1'b0;
        chk("run_completed", 384'(done_cyc != 0), 384'(1));
    endtask

    initial begin
        init_x = {32'h3ef710c0, 32'h3efaa476, 32'hbf627778};
        for (int j = 0; j < NS; j++) init_state[32*j +: 32] = 32'h3f800000 + 32'(j);

        #12;
        chk("rst_busy",   384'(busy), 384'(0));
        chk("rst_cstart", 384'(core_start), 384'(0));
        chk("rst_done",   384'(done), 384'(0));
        chk("rst_status", 384'(status), 384'(0));
        chk("rst_iter",   384'(iter_count), 384'(0));
        chk("rst_x",      384'(x_out), 384'(0));
        chk("rst_state",  384'(state_out), 384'(0));
        @(negedge clk);
        rst = 1'b1;

        mode = M_ECHO;
        run(100);
        chk("conv_first_cs", 384'(first_cs), 384'(1));
        chk("conv_done_cyc", 384'(done_cyc), 384'(6));
        chk("conv_status",   384'(status), 384'(0));
        chk("conv_iter",     384'(iter_count), 384'(1));
        chk("conv_x",        384'(x_out), 384'(init_x));
        chk("conv_state",    384'(state_out), 384'(init_state));

        mode = M_FIRST; alt_x0 = 32'hbf62777b;
        run(100);
        chk("tol3_status", 384'(status), 384'(0));
        chk("tol3_iter",   384'(iter_count), 384'(1));
        chk("tol3_x0",     384'(x_out[31:0]), 384'(32'hbf62777b));

        mode = M_FIRST; alt_x0 = 32'hbf62777c;
        run(100);
        chk("tol4_status", 384'(status), 384'(0));
        chk("tol4_iter",   384'(iter_count), 384'(2));
        chk("tol4_starts", 384'(n_start), 384'(2));
        chk("tol4_done",   384'(done_cyc), 384'(11));
        chk("tol4_x0",     384'(x_out[31:0]), 384'(32'hbf62777c));

        mode = M_ADD;
        run(300);
        exp_s = init_state;
        for (int j = 0; j < NS; j++) exp_s[32*j +: 32] = exp_s[32*j +: 32] + 32'd16;
        chk("max_starts", 384'(n_start), 384'(16));
        chk("max_done",   384'(done_cyc), 384'(81));
        chk("max_status", 384'(status), 384'(1));
        chk("max_iter",   384'(iter_count), 384'(16));
        chk("max_x",      384'(x_out), 384'({32'h3ef711c0, 32'h3efaa576, 32'hbf627878}));
        chk("max_state",  384'(state_out), 384'(exp_s));

        mode = M_NAN2;
        run(100);
        exp_s = init_state;
        for (int j = 0; j < NS; j++) exp_s[32*j +: 32] = exp_s[32*j +: 32] + 32'd1;
        exp_x = {32'h3ef710d0, 32'h3efaa486, 32'hbf627788};
        chk("nan_status", 384'(status), 384'(2));
        chk("nan_iter",   384'(iter_count), 384'(2));
        chk("nan_x",      384'(x_out), 384'(exp_x));
        chk("nan_state",  384'(state_out), 384'(exp_s));

        mode = M_NEVER;
        run(1200);
        chk("tmo_first_cs", 384'(first_cs), 384'(1));
        chk("tmo_done_cyc", 384'(done_cyc), 384'(1026));
        chk("tmo_status",   384'(status), 384'(3));
        chk("tmo_iter",     384'(iter_count), 384'(0));
        chk("tmo_x",        384'(x_out), 384'(init_x));

        // Abort while waiting on a silent core.
        mode = M_NEVER;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 384'(busy), 384'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_after", 384'(busy), 384'(0));
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("abort_no_done", 384'(seen_done), 384'(0));
        chk("abort_status",  384'(status), 384'(3));
        chk("abort_iter",    384'(iter_count), 384'(0));

        // Reset during WAIT with a strobe still in flight from the core.
        mode = M_ECHO;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",   384'(busy), 384'(0));
        chk("mid_rst_done",   384'(done), 384'(0));
        chk("mid_rst_status", 384'(status), 384'(0));
        chk("mid_rst_iter",   384'(iter_count), 384'(0));
        chk("mid_rst_x",      384'(x_out), 384'(0));
        chk("mid_rst_state",  384'(state_out), 384'(0));
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0; seen_busy = 0; seen_stb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen_done = 1;
            if (busy) seen_busy = 1;
            if (core_stb) seen_stb = 1;
        end
        chk("post_rst_stb_ignored_busy", 384'(seen_busy), 384'(0));
        chk("post_rst_stb_ignored_done", 384'(seen_done), 384'(0));
        chk("post_rst_iter", 384'(iter_count), 384'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nr_iter_ctrl.md
Name: nr_iter_ctrl

Overview:
Parametrised Newton-Raphson/Broyden iteration sequencer. It wraps one single-step iteration core such as gen_iteration and re-launches that core until the iterate converges, a maximum iteration count is reached, the core returns a non-finite value, or the core stops responding. Variable count and state-word count are generic, so the same controller serves any N-variable solver. All values are IEEE-754 single precision, packed into flat buses with word i at bits [32*i+31:32*i].

Parameters:
N_VARS, 3, number of solution variables x.
N_STATE, 12, number of 32-bit carried state words (inverse-Jacobian terms).
MAX_ITER, 16, iteration limit; must be at least 1.
ITER_W, 5, width of iter_count; must satisfy 2^ITER_W > MAX_ITER.
TOL_LSB, 2, convergence threshold: mantissa difference must be less than 2^TOL_LSB.
TIMEOUT, 1024, maximum cycles spent waiting for core_stb.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request a solve; accepted only in IDLE.
abort  in  1  synchronous cancel; returns to IDLE with no done pulse.
init_x  in  32*N_VARS  initial iterate.
init_state  in  32*N_STATE  initial state words.
busy  out  1  high in every state except IDLE.
core_start  out  1  one-cycle launch pulse to the core.
core_x  out  32*N_VARS  current iterate presented to the core.
core_state  out  32*N_STATE  current state words presented to the core.
core_stb  in  1  core result valid (the core's output_stb).
core_next_x  in  32*N_VARS  core result iterate.
core_next_state  in  32*N_STATE  core result state words.
done  out  1  one-cycle completion pulse.
status  out  2  0 = converged, 1 = max-iter, 2 = non-finite, 3 = timeout; valid from done until next start.
iter_count  out  ITER_W  number of core results captured.
x_out  out  32*N_VARS  final iterate (equals core_x).
state_out  out  32*N_STATE  final state words (equals core_state).

Behaviour:
- Reset (rst=0), asynchronous:
  - State goes to IDLE.
  - All outputs, x/state registers, candidate registers, counters and status clear to 0.
- FSM states: IDLE, LAUNCH, WAIT, CHECK, DONE.
- IDLE:
  - start=1 loads init_x and init_state, clears iter_count and the timeout counter, then moves to LAUNCH.
- LAUNCH:
  - core_start=1 for exactly this cycle; then WAIT.
- WAIT:
  - Timeout counter increments every cycle.
  - core_stb=1: capture core_next_x/core_next_state into candidate registers, increment iter_count, go to CHECK.
  - Counter reaching TIMEOUT with no strobe: status=3, go to DONE.
  - Strobe and timeout in the same cycle: the strobe wins.
- CHECK, priority order:
  - (a) Any candidate x word with exponent 8'hFF: status=2, go to DONE. No commit, so x_out holds the last finite iterate.
  - Otherwise, commit candidates into the x/state registers, then:
  - (b) All variables converged: status=0, go to DONE.
  - (c) iter_count == MAX_ITER: status=1, go to DONE.
  - (d) Otherwise: clear the timeout counter and go to LAUNCH.
- Per-variable convergence test (combinational, candidate vs current):
  - Converged if both exponents are 0 (±0 or denormal), or
  - sign and exponent are equal and the absolute difference of the 23-bit mantissas is less than 2^TOL_LSB.
  - The unsigned subtraction must be 24 bits wide so it never wraps.
- DONE:
  - done=1 for one cycle; then IDLE.
- Cycle timing:
  - start sampled high at edge 0 gives core_start high in cycle 1.
  - core_stb sampled at edge k gives done at edge k+2, or core_start at edge k+2.
- Ignored inputs:
  - start outside IDLE.
  - core_stb outside WAIT.
- abort:
  - Honoured in every non-IDLE state, and takes priority over every other transition.
  - Returns to IDLE with no done pulse; status and iter_count keep their last values.

Test Plan:
- Immediate convergence: init_x = {bf627778, 3efaa476, 3ef710c0}; model core echoes x with a 3-cycle strobe delay. Expect core_start in cycle 1, done in cycle 6, status 0, iter_count 1, x_out unchanged.
- Tolerance edge (TOL_LSB=2): core returns x0 = bf62777b (difference 3), so status 0 after 1 iteration. Core returns bf62777c (difference 4) then echoes, so status 0 after 2 iterations.
- Max iterations: core adds 0x10 to every mantissa on each call. Expect 16 core_start pulses, status 1, iter_count 16, x_out x0 = bf627878.
- Non-finite: on the second call the core returns x1 = 7fc00000. Expect status 2, iter_count 2, x_out equal to the first-iteration result.
- Timeout: core never strobes. Expect done exactly 1024 cycles after entering WAIT, with status 3 and iter_count 0.
- Reset and abort:
  - Drop rst during WAIT: all outputs 0 immediately; a later core_stb is ignored.
  - Pulse abort during WAIT: busy low the next cycle and no done pulse.
